// File: rtl/alu_flag_seq_if.sv
// Instruction/result bundle between register-read, the ALU/branch stage and
// the register-file write port / PC mux.
interface alu_flag_seq_if #(
  parameter int DATA_W = 16,
  parameter int ADR_W  = 4,
  parameter int CNT_W  = 12
);
  logic              valid_i;
  logic [3:0]        op_i;
  logic [ADR_W-1:0]  adr_i;
  logic [DATA_W-1:0] a_i;
  logic [DATA_W-1:0] b_i;
  logic [CNT_W-1:0]  tgt_i;
  logic              haz_i;
  logic              busy_o;
  logic              wr_ena_o;
  logic [ADR_W-1:0]  wr_adr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic              jmp_ena_o;
  logic [CNT_W-1:0]  jmp_tgt_o;
  logic              end_o;
  logic              haz_o;
  logic [5:0]        flags_o;

  modport master (
    output valid_i, op_i, adr_i, a_i, b_i, tgt_i, haz_i,
    input  busy_o, wr_ena_o, wr_adr_o, wr_data_o, jmp_ena_o, jmp_tgt_o,
           end_o, haz_o, flags_o
  );

  modport slave (
    input  valid_i, op_i, adr_i, a_i, b_i, tgt_i, haz_i,
    output busy_o, wr_ena_o, wr_adr_o, wr_data_o, jmp_ena_o, jmp_tgt_o,
           end_o, haz_o, flags_o
  );
endinterface

// File: rtl/alu_flag_seq.sv
// Registered ALU / branch-resolve stage owning the architectural flag register,
// with an iterative shift-add MUL and a sticky HALT state.
module alu_flag_seq #(
  parameter int DATA_W = 16,
  parameter int ADR_W  = 4,
  parameter int CNT_W  = 12,
  parameter bit MUL_EN = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  alu_flag_seq_if.slave  bus
);

  localparam logic [3:0] OP_ADD = 4'd1,  OP_MOV = 4'd2,  OP_CMP = 4'd3,
                         OP_SEE = 4'd4,  OP_OR  = 4'd5,  OP_AND = 4'd6,
                         OP_JMP = 4'd7,  OP_JN  = 4'd8,  OP_INC = 4'd9,
                         OP_DEC = 4'd10, OP_END = 4'd11, OP_JR  = 4'd12,
                         OP_SUB = 4'd13, OP_MUL = 4'd14;
  localparam int MC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DATA_W:0] ONE_X = (DATA_W+1)'(1);

  typedef enum logic [1:0] {S_RUN, S_MUL, S_HALT} state_t;

  state_t            state_p1;
  logic              busy_p1, wr_ena_p1, jmp_ena_p1, end_p1, haz_p1;
  logic [ADR_W-1:0]  wr_adr_p1;
  logic [DATA_W-1:0] wr_data_p1;
  logic [CNT_W-1:0]  jmp_tgt_p1;
  logic              rav_p1, carry_p1, zero_p1, gt_p1, lt_p1, eq_p1;
  logic [DATA_W-1:0] mul_a_p1, mul_b_p1, mul_acc_p1;
  logic [MC_W-1:0]   mul_cnt_p1;

  logic              vld_p0;
  logic [DATA_W:0]   add_x_p0, sub_x_p0, inc_x_p0, dec_x_p0;
  logic [DATA_W-1:0] or_p0, and_p0, mul_step;

  function automatic logic is_zero(input logic [DATA_W-1:0] v);
    return (v == '0);
  endfunction

  // Stage 0: decode-side operands, carry/borrow taken from the extra top bit
  assign vld_p0   = bus.valid_i & ~busy_p1;
  assign add_x_p0 = {1'b0, bus.a_i} + {1'b0, bus.b_i};
  assign sub_x_p0 = {1'b0, bus.a_i} - {1'b0, bus.b_i};
  assign inc_x_p0 = {1'b0, bus.b_i} + ONE_X;
  assign dec_x_p0 = {1'b0, bus.b_i} - ONE_X;
  assign or_p0    = bus.a_i | bus.b_i;
  assign and_p0   = bus.a_i & bus.b_i;
  // MSB-first shift-add: acc = 2*acc + (multiplier bit ? multiplicand : 0)
  assign mul_step = (mul_acc_p1 << 1) + (mul_b_p1[DATA_W-1] ? mul_a_p1 : '0);

  // Stage 1: registered results, flags and sequencer state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_p1   <= S_RUN;
      busy_p1    <= 1'b0;
      wr_ena_p1  <= 1'b0;
      jmp_ena_p1 <= 1'b0;
      end_p1     <= 1'b0;
      haz_p1     <= 1'b0;
      wr_adr_p1  <= '0;
      wr_data_p1 <= '0;
      jmp_tgt_p1 <= '0;
      rav_p1     <= 1'b0;
      carry_p1   <= 1'b0;
      zero_p1    <= 1'b0;
      gt_p1      <= 1'b0;
      lt_p1      <= 1'b0;
      eq_p1      <= 1'b0;
      mul_cnt_p1 <= '0;
    end else begin
      haz_p1     <= bus.haz_i;
      wr_ena_p1  <= 1'b0;
      jmp_ena_p1 <= 1'b0;
      case (state_p1)
        S_RUN: if (vld_p0) begin
          wr_adr_p1 <= bus.adr_i;
          case (bus.op_i)
            OP_ADD: begin
              wr_ena_p1  <= 1'b1;
              wr_data_p1 <= add_x_p0[DATA_W-1:0];
              carry_p1   <= add_x_p0[DATA_W];
              zero_p1    <= is_zero(add_x_p0[DATA_W-1:0]);
            end
            OP_SUB: begin
              wr_ena_p1  <= 1'b1;
              wr_data_p1 <= sub_x_p0[DATA_W-1:0];
              carry_p1   <= sub_x_p0[DATA_W];
              zero_p1    <= is_zero(sub_x_p0[DATA_W-1:0]);
            end
            OP_INC: begin
              wr_ena_p1  <= 1'b1;
              wr_data_p1 <= inc_x_p0[DATA_W-1:0];
              carry_p1   <= inc_x_p0[DATA_W];
              zero_p1    <= is_zero(inc_x_p0[DATA_W-1:0]);
            end
            OP_DEC: begin
              wr_ena_p1  <= 1'b1;
              wr_data_p1 <= dec_x_p0[DATA_W-1:0];
              carry_p1   <= dec_x_p0[DATA_W];
              zero_p1    <= is_zero(dec_x_p0[DATA_W-1:0]);
            end
            OP_MOV: begin
              wr_ena_p1  <= 1'b1;
              wr_data_p1 <= bus.b_i;
              zero_p1    <= is_zero(bus.b_i);
            end
            OP_OR: begin
              wr_ena_p1  <= 1'b1;
              wr_data_p1 <= or_p0;
              zero_p1    <= is_zero(or_p0);
            end
            OP_AND: begin
              wr_ena_p1  <= 1'b1;
              wr_data_p1 <= and_p0;
              zero_p1    <= is_zero(and_p0);
            end
            OP_CMP: begin
              gt_p1 <= (bus.a_i > bus.b_i);
              lt_p1 <= (bus.a_i < bus.b_i);
              eq_p1 <= (bus.a_i == bus.b_i);
            end
            OP_SEE: rav_p1 <= (bus.a_i[4:0] == bus.b_i[4:0]) && (bus.a_i < bus.b_i);
            OP_JMP: begin
              jmp_ena_p1 <= 1'b1;
              jmp_tgt_p1 <= bus.tgt_i;
            end
            OP_JN: begin
              jmp_ena_p1 <= ~gt_p1;
              jmp_tgt_p1 <= bus.tgt_i;
            end
            OP_JR: begin
              jmp_ena_p1 <= rav_p1;
              jmp_tgt_p1 <= bus.tgt_i;
            end
            OP_END: begin
              end_p1   <= 1'b1;
              busy_p1  <= 1'b1;
              state_p1 <= S_HALT;
            end
            OP_MUL: if (MUL_EN) begin
              mul_a_p1   <= bus.a_i;
              mul_b_p1   <= bus.b_i;
              mul_acc_p1 <= '0;
              mul_cnt_p1 <= MC_W'(DATA_W - 1);
              busy_p1    <= 1'b1;
              state_p1   <= S_MUL;
            end
            default: ;
          endcase
        end
        S_MUL: begin
          mul_b_p1 <= mul_b_p1 << 1;
          if (mul_cnt_p1 == '0) begin
            // Last partial product goes straight to the write port
            wr_ena_p1  <= 1'b1;
            wr_data_p1 <= mul_step;
            zero_p1    <= is_zero(mul_step);
            busy_p1    <= 1'b0;
            state_p1   <= S_RUN;
          end else begin
            mul_acc_p1 <= mul_step;
            mul_cnt_p1 <= mul_cnt_p1 - 1'b1;
          end
        end
        S_HALT: ;
        default: state_p1 <= S_RUN;
      endcase
    end
  end

  assign bus.busy_o    = busy_p1;
  assign bus.wr_ena_o  = wr_ena_p1;
  assign bus.wr_adr_o  = wr_adr_p1;
  assign bus.wr_data_o = wr_data_p1;
  assign bus.jmp_ena_o = jmp_ena_p1;
  assign bus.jmp_tgt_o = jmp_tgt_p1;
  assign bus.end_o     = end_p1;
  assign bus.haz_o     = haz_p1;
  assign bus.flags_o   = {rav_p1, carry_p1, zero_p1, gt_p1, lt_p1, eq_p1};

endmodule

// File: tb/tb_alu_flag_seq.sv
// Directed bench for alu_flag_seq: arithmetic/flags, branches, MUL timing,
// reset during MUL, HALT and hazard delay.
module tb_alu_flag_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  alu_flag_seq_if bus ();
  alu_flag_seq dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic [5:0]  f;
  } vec_t;

  // flags = {rav, carry, zero, gt, lt, eq}
  vec_t av [9] = '{
    '{4'd1,  16'hFFFF, 16'h0002, 16'h0001, 6'h10},
    '{4'd1,  16'hFFFF, 16'h0001, 16'h0000, 6'h18},
    '{4'd13, 16'h0003, 16'h0005, 16'hFFFE, 6'h10},
    '{4'd13, 16'h0005, 16'h0003, 16'h0002, 6'h00},
    '{4'd9,  16'h0000, 16'hFFFF, 16'h0000, 6'h18},
    '{4'd10, 16'h0000, 16'h0000, 16'hFFFF, 6'h10},
    '{4'd5,  16'h00F0, 16'h0F00, 16'h0FF0, 6'h10},
    '{4'd6,  16'h00F0, 16'h0F00, 16'h0000, 6'h18},
    '{4'd2,  16'h0000, 16'h1234, 16'h1234, 6'h10}
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] adr, input logic [11:0] tgt);
    bus.valid_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.adr_i   = adr;
    bus.tgt_i   = tgt;
  endtask

  task automatic idle();
    bus.valid_i = 1'b0;
    bus.op_i    = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); tick(); tick();
    vecs++; if (bus.busy_o !== 1'b0) begin errs++; $display("FAIL rst_busy got %b exp 0", bus.busy_o); end
    vecs++; if (bus.wr_ena_o !== 1'b0) begin errs++; $display("FAIL rst_wr_ena got %b exp 0", bus.wr_ena_o); end
    vecs++; if (bus.jmp_ena_o !== 1'b0) begin errs++; $display("FAIL rst_jmp_ena got %b exp 0", bus.jmp_ena_o); end
    vecs++; if (bus.end_o !== 1'b0) begin errs++; $display("FAIL rst_end got %b exp 0", bus.end_o); end
    vecs++; if (bus.flags_o !== 6'h00) begin errs++; $display("FAIL rst_flags got %h exp 00", bus.flags_o); end
    vecs++; if (bus.wr_data_o !== 16'h0) begin errs++; $display("FAIL rst_wr_data got %h exp 0000", bus.wr_data_o); end
    rst = 1'b0;
  endtask

  task automatic test_arith();
    for (int i = 0; i < 9; i++) begin
      drive(av[i].op, av[i].a, av[i].b, 4'(i + 3), 12'h0);
      tick();
      vecs++; if (bus.wr_ena_o !== 1'b1) begin errs++; $display("FAIL arith%0d_wr_ena got %b exp 1", i, bus.wr_ena_o); end
      vecs++; if (bus.wr_adr_o !== 4'(i + 3)) begin errs++; $display("FAIL arith%0d_wr_adr got %h exp %h", i, bus.wr_adr_o, 4'(i + 3)); end
      vecs++; if (bus.wr_data_o !== av[i].d) begin errs++; $display("FAIL arith%0d_wr_data got %h exp %h", i, bus.wr_data_o, av[i].d); end
      vecs++; if (bus.flags_o !== av[i].f) begin errs++; $display("FAIL arith%0d_flags got %h exp %h", i, bus.flags_o, av[i].f); end
    end
    idle(); tick();
    vecs++; if (bus.wr_ena_o !== 1'b0) begin errs++; $display("FAIL arith_pulse got %b exp 0", bus.wr_ena_o); end
  endtask

  task automatic test_cmp_jn();
    drive(4'd3, 16'd5, 16'd9, 4'd1, 12'h0); tick();
    vecs++; if (bus.flags_o !== 6'h12) begin errs++; $display("FAIL cmp_lt_flags got %h exp 12", bus.flags_o); end
    vecs++; if (bus.wr_ena_o !== 1'b0) begin errs++; $display("FAIL cmp_no_write got %b exp 0", bus.wr_ena_o); end
    drive(4'd8, 16'd0, 16'd0, 4'd1, 12'h040); tick();
    vecs++; if (bus.jmp_ena_o !== 1'b1) begin errs++; $display("FAIL jn_taken got %b exp 1", bus.jmp_ena_o); end
    vecs++; if (bus.jmp_tgt_o !== 12'h040) begin errs++; $display("FAIL jn_tgt got %h exp 040", bus.jmp_tgt_o); end
    drive(4'd3, 16'd9, 16'd5, 4'd1, 12'h0); tick();
    vecs++; if (bus.flags_o !== 6'h14) begin errs++; $display("FAIL cmp_gt_flags got %h exp 14", bus.flags_o); end
    vecs++; if (bus.jmp_ena_o !== 1'b0) begin errs++; $display("FAIL jmp_pulse got %b exp 0", bus.jmp_ena_o); end
    drive(4'd8, 16'd0, 16'd0, 4'd1, 12'h080); tick();
    vecs++; if (bus.jmp_ena_o !== 1'b0) begin errs++; $display("FAIL jn_not_taken got %b exp 0", bus.jmp_ena_o); end
  endtask

  task automatic test_see_jr();
    drive(4'd4, 16'h0023, 16'h0043, 4'd0, 12'h0); tick();
    vecs++; if (bus.flags_o !== 6'h34) begin errs++; $display("FAIL see_set_flags got %h exp 34", bus.flags_o); end
    drive(4'd12, 16'h0, 16'h0, 4'd0, 12'h010); tick();
    vecs++; if (bus.jmp_ena_o !== 1'b1) begin errs++; $display("FAIL jr_taken got %b exp 1", bus.jmp_ena_o); end
    vecs++; if (bus.jmp_tgt_o !== 12'h010) begin errs++; $display("FAIL jr_tgt got %h exp 010", bus.jmp_tgt_o); end
    drive(4'd4, 16'h0043, 16'h0023, 4'd0, 12'h0); tick();
    vecs++; if (bus.flags_o !== 6'h14) begin errs++; $display("FAIL see_clr_flags got %h exp 14", bus.flags_o); end
    drive(4'd12, 16'h0, 16'h0, 4'd0, 12'h020); tick();
    vecs++; if (bus.jmp_ena_o !== 1'b0) begin errs++; $display("FAIL jr_not_taken got %b exp 0", bus.jmp_ena_o); end
    drive(4'd7, 16'h0, 16'h0, 4'd0, 12'h123); tick();
    vecs++; if ({bus.jmp_ena_o, bus.jmp_tgt_o} !== {1'b1, 12'h123}) begin errs++; $display("FAIL jmp got %b/%h exp 1/123", bus.jmp_ena_o, bus.jmp_tgt_o); end
  endtask

  task automatic test_back_to_back();
    drive(4'd14, 16'd300, 16'd300, 4'd5, 12'h0); tick();
    vecs++; if ({bus.busy_o, bus.wr_ena_o} !== 2'b10) begin errs++; $display("FAIL mul_c1 got %b exp 10", {bus.busy_o, bus.wr_ena_o}); end
    drive(4'd1, 16'd1, 16'd2, 4'd7, 12'h0);
    for (int c = 2; c <= 16; c++) begin
      tick();
      vecs++; if ({bus.busy_o, bus.wr_ena_o} !== 2'b10) begin errs++; $display("FAIL mul_c%0d got %b exp 10", c, {bus.busy_o, bus.wr_ena_o}); end
    end
    tick();
    vecs++; if ({bus.busy_o, bus.wr_ena_o} !== 2'b01) begin errs++; $display("FAIL mul_c17 got %b exp 01", {bus.busy_o, bus.wr_ena_o}); end
    vecs++; if (bus.wr_data_o !== 16'h5F90) begin errs++; $display("FAIL mul_data got %h exp 5f90", bus.wr_data_o); end
    vecs++; if (bus.wr_adr_o !== 4'd5) begin errs++; $display("FAIL mul_adr got %h exp 5", bus.wr_adr_o); end
    tick();
    vecs++; if ({bus.wr_ena_o, bus.wr_adr_o, bus.wr_data_o} !== {1'b1, 4'd7, 16'd3}) begin errs++; $display("FAIL held_add got %b/%h/%h exp 1/7/0003", bus.wr_ena_o, bus.wr_adr_o, bus.wr_data_o); end
    vecs++; if (bus.flags_o !== 6'h04) begin errs++; $display("FAIL held_add_flags got %h exp 04", bus.flags_o); end
    idle(); tick();
  endtask

  task automatic test_reset_mid_mul();
    drive(4'd3, 16'd1, 16'd2, 4'd0, 12'h0); tick();
    drive(4'd14, 16'd300, 16'd300, 4'd5, 12'h0); tick();
    idle();
    for (int c = 2; c <= 8; c++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    vecs++; if ({bus.busy_o, bus.wr_ena_o, bus.flags_o} !== 8'h00) begin errs++; $display("FAIL mul_rst got %b/%b/%h exp 0/0/00", bus.busy_o, bus.wr_ena_o, bus.flags_o); end
    drive(4'd2, 16'd0, 16'd7, 4'd2, 12'h0); tick();
    vecs++; if ({bus.wr_ena_o, bus.wr_adr_o, bus.wr_data_o} !== {1'b1, 4'd2, 16'd7}) begin errs++; $display("FAIL mov_after_rst got %b/%h/%h exp 1/2/0007", bus.wr_ena_o, bus.wr_adr_o, bus.wr_data_o); end
    idle();
    for (int c = 0; c < 12; c++) begin
      tick();
      vecs++; if ({bus.busy_o, bus.wr_ena_o} !== 2'b00) begin errs++; $display("FAIL stale_mul%0d got %b exp 00", c, {bus.busy_o, bus.wr_ena_o}); end
    end
  endtask

  task automatic test_halt();
    drive(4'd11, 16'd0, 16'd0, 4'd0, 12'h0); tick();
    vecs++; if ({bus.end_o, bus.busy_o, bus.wr_ena_o} !== 3'b110) begin errs++; $display("FAIL end got %b exp 110", {bus.end_o, bus.busy_o, bus.wr_ena_o}); end
    for (int c = 0; c < 4; c++) begin
      if (c[0]) drive(4'd3, 16'd1, 16'd2, 4'd0, 12'h0);
      else      drive(4'd1, 16'd1, 16'd2, 4'd4, 12'h0);
      tick();
      vecs++; if ({bus.end_o, bus.busy_o, bus.wr_ena_o, bus.flags_o} !== {3'b110, 6'h00}) begin errs++; $display("FAIL halt%0d got %b/%h exp 110/00", c, {bus.end_o, bus.busy_o, bus.wr_ena_o}, bus.flags_o); end
    end
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    vecs++; if ({bus.end_o, bus.busy_o} !== 2'b00) begin errs++; $display("FAIL halt_rst got %b exp 00", {bus.end_o, bus.busy_o}); end
  endtask

  task automatic test_haz();
    idle();
    bus.haz_i = 1'b1; tick();
    vecs++; if (bus.haz_o !== 1'b1) begin errs++; $display("FAIL haz_set got %b exp 1", bus.haz_o); end
    bus.haz_i = 1'b0; tick();
    vecs++; if (bus.haz_o !== 1'b0) begin errs++; $display("FAIL haz_clr got %b exp 0", bus.haz_o); end
  endtask

  initial begin
    bus.valid_i = 1'b0; bus.op_i = 4'd0; bus.adr_i = '0; bus.a_i = '0;
    bus.b_i = '0; bus.tgt_i = '0; bus.haz_i = 1'b0;
    test_reset();
    test_arith();
    test_cmp_jn();
    test_see_jr();
    test_back_to_back();
    test_reset_mid_mul();
    test_halt();
    test_haz();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
